// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three producer FIFOs drained round-robin onto the single ROB
// result write port, with mispredict flush and a global stall.
module cdb_arbiter #(
    parameter int Q_WIDTH    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               alu_valid,
    input  logic [Q_WIDTH-1:0] alu_rob_pos,
    input  logic [31:0]        alu_value,
    input  logic [31:0]        alu_npc,
    output logic               alu_ready,
    input  logic               lsb_valid,
    input  logic [Q_WIDTH-1:0] lsb_rob_pos,
    input  logic [31:0]        lsb_value,
    input  logic [31:0]        lsb_npc,
    output logic               lsb_ready,
    input  logic               bru_valid,
    input  logic [Q_WIDTH-1:0] bru_rob_pos,
    input  logic [31:0]        bru_value,
    input  logic [31:0]        bru_npc,
    output logic               bru_ready,
    output logic               cdb_valid,
    output logic [Q_WIDTH-1:0] cdb_rob_pos,
    output logic [31:0]        cdb_value,
    output logic [31:0]        cdb_npc,
    output logic [1:0]         cdb_src
);
    localparam int NP = 3;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = Q_WIDTH + 64;
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(0);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [NP-1:0] w_in_valid;
    logic [NP-1:0] w_ready;
    logic [NP-1:0] w_push;
    logic [NP-1:0] w_pop;
    logic [EW-1:0] w_in_data [NP];
    logic [EW-1:0] r_mem [NP][FIFO_DEPTH];
    logic [PW-1:0] r_head [NP];
    logic [PW-1:0] r_tail [NP];
    logic [PW:0]   r_count [NP];
    logic [1:0]    r_ptr;
    logic [1:0]    w_win;
    logic [1:0]    w_ptr_nxt;
    logic          w_any;
    logic          w_grant;
    logic [EW-1:0] w_head;

    // Producer index reached after stepping 'off' places from 'base' around the ring of three.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    assign w_in_valid   = {bru_valid, lsb_valid, alu_valid};
    assign w_in_data[0] = {alu_rob_pos, alu_value, alu_npc};
    assign w_in_data[1] = {lsb_rob_pos, lsb_value, lsb_npc};
    assign w_in_data[2] = {bru_rob_pos, bru_value, bru_npc};

    // Per-producer handshake: ready from the registered count only, flush discards offers.
    always_comb begin
        w_ready = '0;
        w_push  = '0;
        w_pop   = '0;
        for (int p = 0; p < NP; p++) begin
            w_ready[p] = rst_in && rdy_in && (r_count[p] < CNT_FULL);
            w_push[p]  = w_in_valid[p] && w_ready[p] && !flush_in;
            w_pop[p]   = w_grant && (w_win == 2'(p));
        end
    end

    // Round-robin scan: first non-empty FIFO starting at the pointer wins.
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        for (int i = 0; i < NP; i++) begin
            if (!w_any && (r_count[rr_idx(r_ptr, 2'(i))] != CNT_ZERO)) begin
                w_any = 1'b1;
                w_win = rr_idx(r_ptr, 2'(i));
            end else begin
                w_any = w_any;
            end
        end
    end

    // Pointer moves just past the winner.
    always_comb begin
        case (w_win)
            2'd0:    w_ptr_nxt = 2'd1;
            2'd1:    w_ptr_nxt = 2'd2;
            default: w_ptr_nxt = 2'd0;
        endcase
    end

    assign w_grant = rdy_in && rst_in && !flush_in && w_any;
    assign w_head  = r_mem[w_win][r_head[w_win]];

    assign alu_ready = w_ready[0];
    assign lsb_ready = w_ready[1];
    assign bru_ready = w_ready[2];

    // Head data stays visible during a stall so the bus does not glitch while frozen.
    assign cdb_valid = w_grant;
    assign cdb_src   = w_grant ? w_win : 2'd3;
    assign {cdb_rob_pos, cdb_value, cdb_npc} = (rst_in && w_any) ? w_head : {EW{1'b0}};

    // FIFO storage write; push is already gated by reset, stall and flush.
    always_ff @(posedge clk_in) begin
        for (int p = 0; p < NP; p++) begin
            if (w_push[p]) begin
                r_mem[p][r_tail[p]] <= w_in_data[p];
            end
        end
    end

    // FIFO pointers, occupancy and round-robin pointer; reset beats flush beats push/pop.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int p = 0; p < NP; p++) begin
                r_head[p]  <= PTR_ZERO;
                r_tail[p]  <= PTR_ZERO;
                r_count[p] <= CNT_ZERO;
            end
            r_ptr <= 2'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int p = 0; p < NP; p++) begin
                    r_head[p]  <= PTR_ZERO;
                    r_tail[p]  <= PTR_ZERO;
                    r_count[p] <= CNT_ZERO;
                end
                r_ptr <= 2'd0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (w_push[p]) r_tail[p] <= r_tail[p] + PTR_ONE;
                    if (w_pop[p])  r_head[p] <= r_head[p] + PTR_ONE;
                    case ({w_push[p], w_pop[p]})
                        2'b10:   r_count[p] <= r_count[p] + CNT_ONE;
                        2'b01:   r_count[p] <= r_count[p] - CNT_ONE;
                        default: r_count[p] <= r_count[p];
                    endcase
                end
                if (w_grant) r_ptr <= w_ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs change 1 ns after each rising edge,
// outputs are checked 1 ns later with immediate assertions.
module tb_cdb_arbiter;
    logic        clk_in, rst_in, rdy_in, flush_in;
    logic        alu_valid, lsb_valid, bru_valid;
    logic [3:0]  alu_rob_pos, lsb_rob_pos, bru_rob_pos;
    logic [31:0] alu_value, lsb_value, bru_value;
    logic [31:0] alu_npc, lsb_npc, bru_npc;
    logic        alu_ready, lsb_ready, bru_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_pos;
    logic [31:0] cdb_value, cdb_npc;
    logic [1:0]  cdb_src;
    int          n_checks = 0;
    int          n_errors = 0;
    int          a_idx, l_idx;
    logic        a_acc, l_acc;

    cdb_arbiter #(.Q_WIDTH(4), .FIFO_DEPTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_value(alu_value),
        .alu_npc(alu_npc), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_value(lsb_value),
        .lsb_npc(lsb_npc), .lsb_ready(lsb_ready),
        .bru_valid(bru_valid), .bru_rob_pos(bru_rob_pos), .bru_value(bru_value),
        .bru_npc(bru_npc), .bru_ready(bru_ready),
        .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_value(cdb_value),
        .cdb_npc(cdb_npc), .cdb_src(cdb_src)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] src, input logic [3:0] pos,
                           input logic [31:0] val, input logic [31:0] npc);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'd1);
        chk({tag, ".src"}, 64'(cdb_src), 64'(src));
        chk({tag, ".pos"}, 64'(cdb_rob_pos), 64'(pos));
        chk({tag, ".value"}, 64'(cdb_value), 64'(val));
        chk({tag, ".npc"}, 64'(cdb_npc), 64'(npc));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'd0);
        chk({tag, ".src"}, 64'(cdb_src), 64'd3);
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(exp));
        chk({tag, ".lsb_ready"}, 64'(lsb_ready), 64'(exp));
        chk({tag, ".bru_ready"}, 64'(bru_ready), 64'(exp));
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        alu_valid = 1'b0; lsb_valid = 1'b0; bru_valid = 1'b0;
        alu_rob_pos = 4'd0; lsb_rob_pos = 4'd0; bru_rob_pos = 4'd0;
        alu_value = 32'd0; lsb_value = 32'd0; bru_value = 32'd0;
        alu_npc = 32'd0; lsb_npc = 32'd0; bru_npc = 32'd0;
        tick(); tick();
        #1;
        chk_ready("reset", 1'b0);
        chk_idle("reset");
        chk("reset.value", 64'(cdb_value), 64'd0);

        // Single ALU result: one-cycle latency, then bus idle.
        rst_in = 1'b1;
        #1;
        chk_ready("released", 1'b1);
        alu_valid = 1'b1; alu_rob_pos = 4'd3; alu_value = 32'h11; alu_npc = 32'h104;
        tick();
        alu_valid = 1'b0;
        #1;
        chk_bus("t1.bcast", 2'd0, 4'd3, 32'h11, 32'h104);
        tick();
        #1;
        chk_idle("t1.after");

        // Flush an empty arbiter to put the pointer back on the ALU.
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;

        // All three push together: ALU, LSB, BRU on consecutive cycles.
        alu_valid = 1'b1; alu_rob_pos = 4'd1; alu_value = 32'hA1; alu_npc = 32'h200;
        lsb_valid = 1'b1; lsb_rob_pos = 4'd2; lsb_value = 32'hB2; lsb_npc = 32'h204;
        bru_valid = 1'b1; bru_rob_pos = 4'd3; bru_value = 32'hC3; bru_npc = 32'h208;
        tick();
        alu_valid = 1'b0; lsb_valid = 1'b0; bru_valid = 1'b0;
        #1; chk_bus("t2.alu", 2'd0, 4'd1, 32'hA1, 32'h200);
        tick();
        #1; chk_bus("t2.lsb", 2'd1, 4'd2, 32'hB2, 32'h204);
        tick();
        #1; chk_bus("t2.bru", 2'd2, 4'd3, 32'hC3, 32'h208);
        tick();
        #1; chk_idle("t2.done");

        // ALU and LSB stream continuously: grants alternate, ALU backpressures.
        a_idx = 0; l_idx = 0;
        alu_valid = 1'b1; lsb_valid = 1'b1;
        alu_value = 32'h1000; lsb_value = 32'h2000;
        alu_rob_pos = 4'd0; lsb_rob_pos = 4'd8;
        for (int c = 0; c < 7; c++) begin
            #1;
            chk("t3.alu_ready", 64'(alu_ready), (c >= 3 && c % 2 == 1) ? 64'd0 : 64'd1);
            if (c >= 1) begin
                chk("t3.src", 64'(cdb_src), (c % 2 == 1) ? 64'd0 : 64'd1);
                chk("t3.value", 64'(cdb_value),
                    (c % 2 == 1) ? 64'(32'h1000 + (c - 1) / 2) : 64'(32'h2000 + (c - 2) / 2));
            end
            a_acc = alu_ready; l_acc = lsb_ready;
            tick();
            if (a_acc) a_idx++;
            if (l_acc) l_idx++;
            alu_value = 32'h1000 + 32'(a_idx); alu_rob_pos = 4'(a_idx);
            lsb_value = 32'h2000 + 32'(l_idx); lsb_rob_pos = 4'(l_idx + 8);
        end
        alu_valid = 1'b0; lsb_valid = 1'b0;
        flush_in = 1'b1;
        #1; chk("t3.flush_valid", 64'(cdb_valid), 64'd0);
        tick();
        flush_in = 1'b0;

        // Two BRU entries buffered, then flush with fresh offers that must vanish.
        alu_valid = 1'b1; alu_rob_pos = 4'd4; alu_value = 32'h41; alu_npc = 32'h500;
        lsb_valid = 1'b1; lsb_rob_pos = 4'd6; lsb_value = 32'h61; lsb_npc = 32'h504;
        bru_valid = 1'b1; bru_rob_pos = 4'd5; bru_value = 32'h51; bru_npc = 32'h508;
        tick();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        bru_rob_pos = 4'd6; bru_value = 32'h52;
        #1;
        chk_bus("t4.alu", 2'd0, 4'd4, 32'h41, 32'h500);
        chk("t4.bru_ready", 64'(bru_ready), 64'd1);
        tick();
        flush_in = 1'b1;
        alu_valid = 1'b1; alu_value = 32'hDEAD;
        bru_value = 32'h53;
        #1;
        chk_idle("t4.flush");
        chk("t4.bru_full", 64'(bru_ready), 64'd0);
        chk("t4.alu_ready", 64'(alu_ready), 64'd1);
        tick();
        flush_in = 1'b0; alu_valid = 1'b0; bru_valid = 1'b0;
        #1;
        chk_idle("t4.post");
        chk_ready("t4.post", 1'b1);
        chk("t4.post.value", 64'(cdb_value), 64'd0);
        tick();
        #1; chk_idle("t4.post2");

        // Stall with one ALU entry: frozen three cycles, then broadcast.
        alu_valid = 1'b1; alu_rob_pos = 4'd7; alu_value = 32'h77; alu_npc = 32'h300;
        tick();
        alu_valid = 1'b0; rdy_in = 1'b0;
        repeat (3) begin
            #1;
            chk_idle("t5.stall");
            chk("t5.alu_ready", 64'(alu_ready), 64'd0);
            chk("t5.hold_value", 64'(cdb_value), 64'h77);
            tick();
        end
        rdy_in = 1'b1;
        #1; chk_bus("t5.resume", 2'd0, 4'd7, 32'h77, 32'h300);
        tick();
        #1; chk_idle("t5.done");

        // Reset while loaded: everything discarded, ALU wins first afterwards.
        alu_valid = 1'b1; lsb_valid = 1'b1; bru_valid = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        #1;
        chk_ready("t6.rst", 1'b0);
        chk_idle("t6.rst");
        chk("t6.rst.value", 64'(cdb_value), 64'd0);
        rst_in = 1'b1;
        alu_rob_pos = 4'd9;  alu_value = 32'h90; alu_npc = 32'h400;
        lsb_rob_pos = 4'd10; lsb_value = 32'hA0; lsb_npc = 32'h404;
        bru_rob_pos = 4'd11; bru_value = 32'hB0; bru_npc = 32'h408;
        #1;
        chk_ready("t6.rel", 1'b1);
        chk_idle("t6.rel");
        tick();
        alu_valid = 1'b0; lsb_valid = 1'b0; bru_valid = 1'b0;
        #1; chk_bus("t6.alu", 2'd0, 4'd9, 32'h90, 32'h400);
        tick();
        #1; chk_bus("t6.lsb", 2'd1, 4'd10, 32'hA0, 32'h404);
        tick();
        #1; chk_bus("t6.bru", 2'd2, 4'd11, 32'hB0, 32'h408);
        tick();
        #1; chk_idle("t6.done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the reorder buffer's single execution-result write port (has_ex_result / target_ROB_pos / V_ex / pc_ex) among three producers: ALU, load/store buffer (loads), and branch unit.
- Each producer pushes results into its own small FIFO with a valid/ready handshake.
- A round-robin scheduler drains at most one entry per cycle onto the common data bus.
- The bus feeds both the ROB and the reservation-station wakeup logic.
- A mispredict flush discards every buffered result.

Parameters:
Q_WIDTH, 4, ROB index width; must match the ROB.
FIFO_DEPTH, 2, entries per producer FIFO; power of two, minimum 2.

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-low
rdy_in  input  1  global enable; low freezes all state
flush_in  input  1  mispredict flush, driven from the ROB control_hazard output
alu_valid  input  1  ALU result offered
alu_rob_pos  input  Q_WIDTH  ALU destination ROB entry
alu_value  input  32  ALU result value
alu_npc  input  32  ALU next-PC
alu_ready  output  1  ALU FIFO can accept
lsb_valid / lsb_rob_pos / lsb_value / lsb_npc / lsb_ready  same widths and directions as the alu_* group; load results
bru_valid / bru_rob_pos / bru_value / bru_npc / bru_ready  same widths and directions as the alu_* group; branch results
cdb_valid  output  1  broadcast valid (drives has_ex_result)
cdb_rob_pos  output  Q_WIDTH  broadcast ROB index
cdb_value  output  32  broadcast value
cdb_npc  output  32  broadcast next-PC
cdb_src  output  2  granted producer: 0 = ALU, 1 = LSB, 2 = BRU, 3 = none

Behaviour:
- Reset (rst_in == 0 at a clock edge):
  - All FIFOs empty; round-robin pointer set to 0 (ALU first).
  - While rst_in is low, all *_ready outputs and cdb_valid are forced to 0.
  - cdb_src = 3; cdb_rob_pos, cdb_value and cdb_npc = 0.
- Ready:
  - x_ready = rst_in && rdy_in && (count_x < FIFO_DEPTH).
  - x_ready is computed from the registered count only.
  - There is no same-cycle pass-through when full, even if that FIFO is popped in the same cycle.
- Push:
  - Occurs when x_valid && x_ready at a clock edge with no flush.
  - The entry {rob_pos, value, npc} is written at the tail.
  - The producer must hold x_valid and its data until the transfer completes; offers while ready is low are not transfers.
- Output path:
  - Combinational from the FIFO heads and the pointer.
  - Minimum latency is 1 cycle: a push at edge N can broadcast in cycle N+1. No bypass from input to bus.
- Grant:
  - Scan producers starting at the pointer, in order pointer, pointer+1, pointer+2 (mod 3).
  - The first non-empty FIFO wins.
  - cdb_valid = rdy_in && rst_in && !flush_in && any FIFO non-empty.
  - cdb_* carry the winner's head entry; cdb_src = the winner's index, or 3 when cdb_valid = 0.
- Pop and pointer update:
  - At an edge with cdb_valid = 1, the winner's head is popped.
  - The pointer becomes (winner + 1) mod 3.
  - When nothing is granted, the pointer holds.
- Simultaneous push and pop on one FIFO: the count is unchanged and both pointers advance.
  - Only possible when count < FIFO_DEPTH before the edge.
- Wrap-around:
  - Head and tail pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count is log2(FIFO_DEPTH)+1 bits.
- Flush (flush_in && rdy_in at an edge):
  - All FIFOs cleared; pointer reset to 0.
  - Pushes offered in that cycle are discarded.
  - cdb_valid is 0 during the flush cycle, so a head entry is never both broadcast and flushed.
- Stall (rdy_in == 0):
  - No push, pop, pointer or flush update.
  - cdb_valid = 0 and all *_ready = 0.
  - Head data remains visible on cdb_rob_pos, cdb_value and cdb_npc.
- Reset has priority over flush, and flush has priority over push and pop.
- Reset asserted mid-operation discards all buffered entries at the next edge.

Test Plan:
- Reset, then ALU push {pos=3, value=0x11, npc=0x104} at edge 1 -> cycle 2: cdb_valid=1, cdb_rob_pos=3, cdb_value=0x11, cdb_npc=0x104, cdb_src=0; cycle 3: cdb_valid=0, cdb_src=3.
- All three producers push one entry in the same cycle (pos 1, 2, 3) -> broadcasts on three consecutive cycles in order ALU, LSB, BRU; the pointer ends at 0.
- Hold alu_valid=1 continuously with FIFO_DEPTH=2 while LSB also holds valid -> grants alternate ALU/LSB; alu_ready drops to 0 after two unpopped pushes and never overflows; no entry is lost or duplicated.
- Fill the BRU FIFO (2 entries), then assert flush_in for one cycle -> cdb_valid=0 in the flush cycle; afterwards all FIFOs are empty and bru_ready=1; a push offered in the flush cycle never appears.
- ALU FIFO holds 1 entry and rdy_in is low for 3 cycles -> cdb_valid=0 and alu_ready=0 throughout, cdb_value holds the head value; the entry broadcasts in the first cycle after rdy_in returns high.
- Drive rst_in=0 with 2 entries buffered in each FIFO -> after the edge all FIFOs are empty and cdb_src=3; after rst_in returns to 1, the first grant goes to the ALU.
